// File: rtl/aes_chk_pkg.sv
// Shared types and default widths for the pipelined cipher response checker.
package aes_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_e;

    localparam int DATA_W_DEF = 128;
    localparam int LAT_DEF    = 21;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with a per-stage valid bit; valids clear on rst or clr_i.
module pipe_delay #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_data_o
);

    logic [D-1:0] vld_q;
    logic [W-1:0] data_q [D];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            for (int k = 1; k < D; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Payload is qualified by vld_q, so it shifts freely without reset.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data_i;
        for (int k = 1; k < D; k++) begin
            data_q[k] <= data_q[k-1];
        end
    end

    assign out_vld_o  = vld_q[D-1];
    assign out_data_o = data_q[D-1];

endmodule

// File: rtl/aes_pipe_checker.sv
// Hardware known-answer monitor: delays each expected value by LATENCY cycles,
// compares it with the core output and keeps run statistics plus the first mismatch.
module aes_pipe_checker
    import aes_chk_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_expected,
    input  logic [DATA_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int PEND_W = $clog2(LATENCY + 1) + CNT_W;
    localparam int ENT_W  = DATA_W + CNT_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    chk_state_e         state_q, state_d;
    logic [CNT_W-1:0]   vec_q, vec_d, err_q, err_d, fidx_q, fidx_d;
    logic [DATA_W-1:0]  fdata_q, fdata_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               err_pulse_q, err_pulse_d;

    logic               accept, clr, pop_vld, mismatch;
    logic [ENT_W-1:0]   push_data, pop_data;
    logic [DATA_W-1:0]  pop_exp;
    logic [CNT_W-1:0]   pop_idx;

    assign accept    = in_valid && (state_q == RUN);
    assign clr       = start && ((state_q == IDLE) || (state_q == DONE));
    assign push_data = {in_expected, vec_q};

    pipe_delay #(.W(ENT_W), .D(LATENCY)) u_delay (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .in_vld_i   (accept),
        .in_data_i  (push_data),
        .out_vld_o  (pop_vld),
        .out_data_o (pop_data)
    );

    assign pop_exp  = pop_data[ENT_W-1:CNT_W];
    assign pop_idx  = pop_data[CNT_W-1:0];
    assign mismatch = pop_vld && (pop_exp != dut_out);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop) state_d = DRAIN;
            DRAIN:   if (pend_q == '0) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d       = vec_q;
        err_d       = err_q;
        fidx_d      = fidx_q;
        fdata_d     = fdata_q;
        pend_d      = pend_q;
        err_pulse_d = mismatch;
        if (clr) begin
            vec_d   = '0;
            err_d   = '0;
            fidx_d  = '0;
            fdata_d = '0;
            pend_d  = '0;
        end else begin
            if (accept) vec_d = sat_inc(vec_q);
            if (mismatch) begin
                err_d = sat_inc(err_q);
                if (err_q == '0) begin
                    fidx_d  = pop_idx;
                    fdata_d = dut_out;
                end
            end
            // Simultaneous push and pop leave the in-flight count unchanged.
            case ({accept, pop_vld})
                2'b10:   pend_d = pend_q + PEND_W'(1);
                2'b01:   pend_d = pend_q - PEND_W'(1);
                default: pend_d = pend_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            err_q       <= '0;
            fidx_q      <= '0;
            fdata_q     <= '0;
            pend_q      <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            err_q       <= err_d;
            fidx_q      <= fidx_d;
            fdata_q     <= fdata_d;
            pend_q      <= pend_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == '0);
    assign err_pulse      = err_pulse_q;
    assign vec_count      = vec_q;
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdata_q;

endmodule

// File: tb/tb_aes_pipe_checker.sv
// Directed bench: a behavioural 21-cycle cipher pipe replays FIPS-197 ciphertexts into the checker.
module tb_aes_pipe_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main checker: 128-bit, 21-cycle latency, 16-bit counters
    logic         start = 0, stop = 0, in_valid = 0;
    logic [127:0] in_expected = '0, dut_out, core_ct = '0;
    logic         busy, done, pass, err_pulse;
    logic [15:0]  vec_count, err_count, first_err_idx;
    logic [127:0] first_err_data;

    // Narrow checker for saturation: 8-bit data, latency 3, 4-bit counters
    logic         s_start = 0, s_stop = 0, s_in_valid = 0;
    logic [7:0]   s_in_exp = '0, s_dut_out = 8'hFF;
    logic         s_busy, s_done, s_pass, s_err_pulse;
    logic [3:0]   s_vec, s_err, s_fidx;
    logic [7:0]   s_fdata;

    logic [127:0] kat_ct [5] = '{
        128'h3925841d02dc09fbdc118597196a0b32,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
        128'h0545aad56da2a97c3663d1432a3d1c84,
        128'h58e2fccefa7e3061367f1d57a4e7455a
    };

    int total = 0;
    int bad   = 0;

    aes_pipe_checker #(.DATA_W(128), .LATENCY(21), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
        .in_expected(in_expected), .dut_out(dut_out), .busy(busy), .done(done),
        .pass(pass), .err_pulse(err_pulse), .vec_count(vec_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    aes_pipe_checker #(.DATA_W(8), .LATENCY(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .in_valid(s_in_valid),
        .in_expected(s_in_exp), .dut_out(s_dut_out), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_pulse(s_err_pulse), .vec_count(s_vec), .err_count(s_err),
        .first_err_idx(s_fidx), .first_err_data(s_fdata)
    );

    // Stand-in for a 21-stage aes_128 core: ciphertext appears 21 cycles after issue
    logic [127:0] core_pipe [21];
    always @(posedge clk) begin
        for (int k = 20; k > 0; k--) core_pipe[k] <= core_pipe[k-1];
        core_pipe[0] <= core_ct;
    end
    assign dut_out = core_pipe[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle vector 0 is driven; outputs observed in cycles 5..44
    task automatic run_kat(input int flip, output int done_cyc, output int pulses, output int pulse_cyc);
        start = 1; tick(); start = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1;
            in_expected = kat_ct[i] ^ ((i == flip) ? 128'd1 : 128'd0);
            core_ct     = kat_ct[i];
            stop        = (i == 4);
            tick();
        end
        in_valid = 0; stop = 0; core_ct = '0;
        done_cyc = -1; pulses = 0; pulse_cyc = -1;
        for (int c = 5; c < 45; c++) begin
            if (err_pulse) begin
                pulses++;
                if (pulse_cyc < 0) pulse_cyc = c;
            end
            if (done && done_cyc < 0) done_cyc = c;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass: got %b want 0", pass); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL rst_err_pulse: got %b want 0", err_pulse); end
        total++; if (vec_count !== 16'd0) begin bad++; $display("FAIL rst_vec: got %0d want 0", vec_count); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", err_count); end
        total++; if (first_err_idx !== 16'd0) begin bad++; $display("FAIL rst_fidx: got %0d want 0", first_err_idx); end
        total++; if (first_err_data !== 128'd0) begin bad++; $display("FAIL rst_fdata: got %h want 0", first_err_data); end
    endtask

    task automatic test_kat_clean();
        int dc, np, pc;
        run_kat(-1, dc, np, pc);
        total++; if (dc !== 27) begin bad++; $display("FAIL clean_done_cycle: got %0d want 27", dc); end
        total++; if (vec_count !== 16'd5) begin bad++; $display("FAIL clean_vec: got %0d want 5", vec_count); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL clean_err: got %0d want 0", err_count); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL clean_pass: got %b want 1", pass); end
        total++; if (np !== 0) begin bad++; $display("FAIL clean_pulses: got %0d want 0", np); end
    endtask

    task automatic test_kat_flip();
        int dc, np, pc;
        run_kat(2, dc, np, pc);
        total++; if (np !== 1) begin bad++; $display("FAIL flip_pulses: got %0d want 1", np); end
        total++; if (pc !== 24) begin bad++; $display("FAIL flip_pulse_cycle: got %0d want 24", pc); end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL flip_err: got %0d want 1", err_count); end
        total++; if (first_err_idx !== 16'd2) begin bad++; $display("FAIL flip_fidx: got %0d want 2", first_err_idx); end
        total++; if (first_err_data !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
            bad++; $display("FAIL flip_fdata: got %h want 66e94bd4ef8a2c3b884cfa59ca342b2e", first_err_data);
        end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL flip_pass: got %b want 0", pass); end
        total++; if (dc !== 27) begin bad++; $display("FAIL flip_done_cycle: got %0d want 27", dc); end
    endtask

    task automatic test_empty_run();
        int dc = -1;
        start = 1; tick(); start = 0;
        stop = 1; tick(); stop = 0;
        for (int c = 1; c < 10; c++) begin
            if (done && dc < 0) dc = c;
            tick();
        end
        total++; if (dc !== 2) begin bad++; $display("FAIL empty_done_cycle: got %0d want 2", dc); end
        total++; if (vec_count !== 16'd0) begin bad++; $display("FAIL empty_vec: got %0d want 0", vec_count); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL empty_err: got %0d want 0", err_count); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL empty_pass: got %b want 1", pass); end
    endtask

    task automatic test_rst_drain();
        int np = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1;
            in_expected = ~kat_ct[i];
            core_ct     = kat_ct[i];
            stop        = (i == 2);
            tick();
        end
        in_valid = 0; stop = 0; core_ct = '0;
        for (int i = 0; i < 4; i++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy: got %b want 1", busy); end
        rst = 1; tick(); rst = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstd_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstd_done: got %b want 0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL rstd_pass: got %b want 0", pass); end
        total++; if (vec_count !== 16'd0) begin bad++; $display("FAIL rstd_vec: got %0d want 0", vec_count); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rstd_err: got %0d want 0", err_count); end
        total++; if (first_err_data !== 128'd0) begin bad++; $display("FAIL rstd_fdata: got %h want 0", first_err_data); end
        for (int c = 0; c < 30; c++) begin
            if (err_pulse) np++;
            tick();
        end
        total++; if (np !== 0) begin bad++; $display("FAIL rstd_pulses: got %0d want 0", np); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rstd_err_late: got %0d want 0", err_count); end
    endtask

    task automatic test_idle_and_restart();
        int dc = -1;
        in_valid = 1; in_expected = kat_ct[0]; core_ct = kat_ct[0]; tick();
        in_valid = 0; core_ct = '0;
        total++; if (vec_count !== 16'd0) begin bad++; $display("FAIL idle_vec: got %0d want 0", vec_count); end
        start = 1; in_valid = 1; tick(); start = 0;
        total++; if (vec_count !== 16'd0) begin bad++; $display("FAIL start_cycle_vec: got %0d want 0", vec_count); end
        for (int i = 0; i < 4; i++) begin
            in_valid    = 1;
            in_expected = kat_ct[i];
            core_ct     = kat_ct[i];
            start       = (i == 2);
            stop        = (i == 3);
            tick();
            if (i == 1) begin
                total++; if (vec_count !== 16'd2) begin bad++; $display("FAIL run_vec2: got %0d want 2", vec_count); end
            end
            if (i == 2) begin
                total++; if (vec_count !== 16'd3) begin bad++; $display("FAIL restart_ignored_vec: got %0d want 3", vec_count); end
            end
        end
        in_valid = 0; start = 0; stop = 0; core_ct = '0;
        for (int c = 0; c < 40 && dc < 0; c++) begin
            if (done) dc = c;
            else tick();
        end
        total++; if (dc < 0) begin bad++; $display("FAIL restart_done_timeout: got %0d want done", dc); end
        total++; if (vec_count !== 16'd4) begin bad++; $display("FAIL restart_vec: got %0d want 4", vec_count); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL restart_err: got %0d want 0", err_count); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL restart_pass: got %b want 1", pass); end
    endtask

    task automatic test_saturation();
        int np = 0;
        s_start = 1; tick(); s_start = 0;
        for (int i = 0; i < 20; i++) begin
            s_in_valid = 1;
            s_in_exp   = 8'(i);
            s_stop     = (i == 19);
            tick();
            if (s_err_pulse) np++;
        end
        s_in_valid = 0; s_stop = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (s_err_pulse) np++;
        end
        total++; if (s_done !== 1'b1) begin bad++; $display("FAIL sat_done: got %b want 1", s_done); end
        total++; if (s_vec !== 4'd15) begin bad++; $display("FAIL sat_vec: got %0d want 15", s_vec); end
        total++; if (s_err !== 4'd15) begin bad++; $display("FAIL sat_err: got %0d want 15", s_err); end
        total++; if (s_fidx !== 4'd0) begin bad++; $display("FAIL sat_fidx: got %0d want 0", s_fidx); end
        total++; if (s_fdata !== 8'hFF) begin bad++; $display("FAIL sat_fdata: got %h want ff", s_fdata); end
        total++; if (s_pass !== 1'b0) begin bad++; $display("FAIL sat_pass: got %b want 0", s_pass); end
        total++; if (np !== 20) begin bad++; $display("FAIL sat_pulses: got %0d want 20", np); end
    endtask

    initial begin
        test_reset();
        test_kat_clean();
        test_kat_flip();
        test_empty_run();
        test_rst_drain();
        test_idle_and_restart();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
